// File: rtl/ep01_hw_checker.sv
// Exhaustive on-chip checker for a 4-input/1-output combinational block:
// sweeps {a,b,c,d} = 0..15, samples f after a settle window and scores it against a truth table.
module ep01_hw_checker #(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail_idx,
    output logic [15:0] fail_mask
);

    localparam int unsigned VEC_W   = 4;
    localparam int unsigned HOLD_W  = 8;
    localparam int unsigned ERR_W   = 5;
    localparam int unsigned NUM_VEC = 16;

    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VEC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [VEC_W-1:0]    idx, idx_n;
    logic [VEC_W-1:0]    stim, stim_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic                busy_n, done_n, pass_n;
    logic [ERR_W-1:0]    err_n;
    logic [VEC_W-1:0]    ffi_n;
    logic [NUM_VEC-1:0]  mask_n;
    logic                miss;

    // Next-state and next-result logic; the final verdict folds in the vector-15 compare.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        stim_n  = stim;
        hold_n  = hold_cnt;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_count;
        ffi_n   = first_fail_idx;
        mask_n  = fail_mask;
        miss    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    idx_n   = '0;
                    stim_n  = '0;
                    hold_n  = HOLD_LOAD;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    ffi_n   = '0;
                    mask_n  = '0;
                    state_n = HOLD;
                end
            end

            HOLD: begin
                if (hold_cnt != '0) begin
                    hold_n = hold_cnt - HOLD_W'(1);
                end else begin
                    // Case inequality so an X/Z on f is scored as a failure.
                    miss = (f !== EXPECTED[idx]);
                    if (miss) begin
                        mask_n[idx] = 1'b1;
                        err_n       = err_count + ERR_W'(1);
                        if (err_count == '0) begin
                            ffi_n = idx;
                        end
                    end
                    if (idx == LAST_VEC) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                        stim_n  = '0;
                        state_n = DONE;
                    end else begin
                        idx_n  = idx + VEC_W'(1);
                        stim_n = idx + VEC_W'(1);
                        hold_n = HOLD_LOAD;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                stim_n  = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            stim           <= '0;
            hold_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            fail_mask      <= '0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            stim           <= stim_n;
            hold_cnt       <= hold_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_fail_idx <= ffi_n;
            fail_mask      <= mask_n;
        end
    end

    assign a = stim[3];
    assign b = stim[2];
    assign c = stim[1];
    assign d = stim[0];

endmodule

// File: tb/tb_ep01_hw_checker.sv
// Bench for ep01_hw_checker: three checker instances with different tables/settle windows,
// each driving a small model of the block under test, scored by a done-triggered scoreboard.
module tb_ep01_hw_checker;

    localparam int NI = 3;
    // Instance tables, low slice = instance 0.
    localparam logic [47:0] EXP_ALL = {16'hB2C4, 16'h00FF, 16'hB2C4};

    typedef struct {
        logic [4:0]  err;
        logic [15:0] mask;
        logic [3:0]  ffi;
        logic        pass;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        rst_n_v [NI];
    logic        start_v [NI];
    logic        f_v     [NI];
    logic        a_v     [NI];
    logic        b_v     [NI];
    logic        c_v     [NI];
    logic        d_v     [NI];
    logic        busy_v  [NI];
    logic        done_v  [NI];
    logic        pass_v  [NI];
    logic [4:0]  err_v   [NI];
    logic [3:0]  ffi_v   [NI];
    logic [15:0] mask_v  [NI];

    logic        model_on [NI];
    logic [15:0] flip     [NI];
    bit          done_q   [NI];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [15:0] EXP_G = EXP_ALL[g*16 +: 16];
        localparam int unsigned SET_G = (g == 2) ? 1 : 2;
        logic [3:0] vec;
        assign vec    = {a_v[g], b_v[g], c_v[g], d_v[g]};
        assign f_v[g] = model_on[g] ? (EXP_G[vec] ^ flip[g][vec]) : 1'b0;

        ep01_hw_checker #(.EXPECTED(EXP_G), .SETTLE(SET_G)) dut (
            .clk            (clk),
            .rst_n          (rst_n_v[g]),
            .start          (start_v[g]),
            .f              (f_v[g]),
            .a              (a_v[g]),
            .b              (b_v[g]),
            .c              (c_v[g]),
            .d              (d_v[g]),
            .busy           (busy_v[g]),
            .done           (done_v[g]),
            .pass           (pass_v[g]),
            .err_count      (err_v[g]),
            .first_fail_idx (ffi_v[g]),
            .fail_mask      (mask_v[g])
        );
    end

    function automatic int settle_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic logic [3:0] vec_of(input int i);
        return {a_v[i], b_v[i], c_v[i], d_v[i]};
    endfunction

    // Every output of an instance packed into one word: {abcd, busy, done, pass, err, ffi, mask}.
    function automatic logic [31:0] snap(input int i);
        return {vec_of(i), busy_v[i], done_v[i], pass_v[i], err_v[i], ffi_v[i], mask_v[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check_done(input int i);
        exp_t e;
        bit   got = 1'b0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected_done: instance %0d raised done with nothing expected", i);
        end else begin
            chk($sformatf("sb%0d_err", i),      32'(err_v[i]),  32'(e.err));
            chk($sformatf("sb%0d_mask", i),     32'(mask_v[i]), 32'(e.mask));
            chk($sformatf("sb%0d_first", i),    32'(ffi_v[i]),  32'(e.ffi));
            chk($sformatf("sb%0d_pass", i),     32'(pass_v[i]), 32'(e.pass));
            chk($sformatf("sb%0d_busy", i),     32'(busy_v[i]), 32'(0));
            chk($sformatf("sb%0d_done_cyc", i), 32'(cyc),       32'(e.done_cyc));
        end
    endtask

    // Monitor: score each rising done against the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (done_v[i] === 1'b1 && !done_q[i]) check_done(i);
            done_q[i] <= (done_v[i] === 1'b1);
        end
    end

    // Issue start, queue the expected verdict, check the accept-edge clear, wait for done.
    task automatic run_sweep(input int i, input logic [4:0] e_err, input logic [15:0] e_mask,
                             input logic [3:0] e_ffi, input logic e_pass);
        exp_t e;
        int   n;
        @(negedge clk);
        start_v[i] = 1'b1;
        e.err = e_err; e.mask = e_mask; e.ffi = e_ffi; e.pass = e_pass;
        e.done_cyc = cyc + 1 + 16 * (settle_of(i) + 1);
        push_exp(i, e);
        @(negedge clk);
        start_v[i] = 1'b0;
        chk($sformatf("accept%0d", i), snap(i), {4'h0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 16'h0});
        n = 0;
        while (done_v[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done_v[i] !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: instance %0d never raised done", i);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        for (int i = 0; i < NI; i++) begin
            rst_n_v[i]  = 1'b0;
            start_v[i]  = 1'b0;
            flip[i]     = 16'h0;
            model_on[i] = (i != 1);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("reset%0d", i), snap(i), 32'h0);
        for (int i = 0; i < NI; i++) rst_n_v[i] = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", snap(0), 32'h0);

        // Correct model, stimulus order and 3-cycle hold, with a start pulse ignored at vector 5.
        @(negedge clk);
        start_v[0] = 1'b1;
        e.err = 5'd0; e.mask = 16'h0; e.ffi = 4'd0; e.pass = 1'b1;
        e.done_cyc = cyc + 1 + 48;
        push_exp(0, e);
        for (int k = 0; k <= 48; k++) begin
            @(negedge clk);
            if (k == 0)  start_v[0] = 1'b0;
            chk($sformatf("stim_k%0d", k), 32'(vec_of(0)), (k < 48) ? 32'(k / 3) : 32'(0));
            chk($sformatf("busy_k%0d", k), 32'(busy_v[0]), (k < 48) ? 32'(1) : 32'(0));
            if (k == 15) start_v[0] = 1'b1;
            if (k == 16) start_v[0] = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("done_hold", snap(0), {4'h0, 1'b0, 1'b1, 1'b1, 5'd0, 4'd0, 16'h0});

        // Table 00FF with f stuck at 0.
        run_sweep(1, 5'd8, 16'h00FF, 4'd0, 1'b0);

        // Model wrong at vectors 10 and 13.
        flip[0] = 16'h2400;
        run_sweep(0, 5'd2, 16'h2400, 4'd10, 1'b0);

        // Asynchronous reset while vector 7 is on the pins, then a clean sweep.
        flip[0] = 16'h0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (vec_of(0) != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec7", 32'(vec_of(0)), 32'd7);
        #2 rst_n_v[0] = 1'b0;
        #1 chk("async_reset", snap(0), 32'h0);
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", snap(0), 32'h0);
        run_sweep(0, 5'd0, 16'h0, 4'd0, 1'b1);

        // SETTLE = 1: failing sweep, then restart from DONE with a fixed model.
        flip[2] = 16'h2400;
        run_sweep(2, 5'd2, 16'h2400, 4'd10, 1'b0);
        flip[2] = 16'h0;
        run_sweep(2, 5'd0, 16'h0, 4'd0, 1'b1);

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
